// File: rtl/change_dispenser_if.sv
// Coin hopper link: 4-phase eject handshake plus tube-empty status.
interface change_dispenser_if;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic       empty25;
  logic       empty10;
  logic       empty5;

  modport master (
    output coin_req,
    output coin_sel,
    input  coin_ack,
    input  empty25,
    input  empty10,
    input  empty5
  );

  modport slave (
    input  coin_req,
    input  coin_sel,
    output coin_ack,
    output empty25,
    output empty10,
    output empty5
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: turns a nickel-count amount into 25c/10c/5c hopper eject requests,
// falling back to smaller coins when a tube is empty and faulting on a stalled handshake.
module change_dispenser #(
  parameter int unsigned AMT_W       = 5,
  parameter int unsigned ACK_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [AMT_W-1:0]    amount,
  change_dispenser_if.master  hopper,
  output logic                busy,
  output logic                done,
  output logic                short,
  output logic                fault,
  output logic [AMT_W-1:0]    remaining
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_5    = 2'b01;
  localparam logic [1:0] SEL_10   = 2'b10;
  localparam logic [1:0] SEL_25   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_d;
  logic [1:0]         sel_d;
  logic [AMT_W-1:0]   rem_d;
  logic               short_d, fault_d, busy_d, done_d;
  logic               timeout_c;
  logic [AMT_W-1:0]   coin_val_c;

  assign timeout_c = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Nickel value of the coin currently being ejected
  always_comb begin
    coin_val_c = '0;
    case (hopper.coin_sel)
      SEL_25:  coin_val_c = AMT_W'(5);
      SEL_10:  coin_val_c = AMT_W'(2);
      SEL_5:   coin_val_c = AMT_W'(1);
      default: coin_val_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      hopper.coin_req <= 1'b0;
      hopper.coin_sel <= SEL_NONE;
      remaining       <= '0;
      short           <= 1'b0;
      fault           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hopper.coin_req <= req_d;
      hopper.coin_sel <= sel_d;
      remaining       <= rem_d;
      short           <= short_d;
      fault           <= fault_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = hopper.coin_req;
    sel_d   = hopper.coin_sel;
    rem_d   = remaining;
    short_d = short;
    fault_d = fault;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = amount;
          short_d = 1'b0;
          fault_d = 1'b0;
          state_d = S_SELECT;
        end
      end

      // A lingering ack from the previous coin holds selection until it clears
      S_SELECT: begin
        if (hopper.coin_ack) begin
          if (timeout_c) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end
        end else if (remaining == '0) begin
          state_d = S_DONE;
        end else if (remaining >= AMT_W'(5) && !hopper.empty25) begin
          sel_d   = SEL_25;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else if (remaining >= AMT_W'(2) && !hopper.empty10) begin
          sel_d   = SEL_10;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else if (!hopper.empty5) begin
          sel_d   = SEL_5;
          req_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          short_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_REQ: begin
        if (hopper.coin_ack) begin
          rem_d   = remaining - coin_val_c;
          req_d   = 1'b0;
          sel_d   = SEL_NONE;
          state_d = S_RELEASE;
        end else if (timeout_c) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          sel_d   = SEL_NONE;
          state_d = S_DONE;
        end
      end

      S_RELEASE: begin
        if (!hopper.coin_ack) begin
          state_d = S_SELECT;
        end else if (timeout_c) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        req_d   = 1'b0;
        sel_d   = SEL_NONE;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    // Handshake watchdog restarts whenever the state changes
    if (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a 2-cycle-latency hopper responder.
module tb_change_dispenser;

  localparam int unsigned AMT_W       = 5;
  localparam int unsigned ACK_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             busy, done, short, fault;
  logic [AMT_W-1:0] remaining;

  change_dispenser_if hif ();

  change_dispenser #(
    .AMT_W       (AMT_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .amount    (amount),
    .hopper    (hif),
    .busy      (busy),
    .done      (done),
    .short     (short),
    .fault     (fault),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit   ack_en = 1'b1;
  int   req_age = 0;
  int   sel_log[$];
  int   rem_log[$];
  int   done_cnt = 0;
  int   req_cycles = 0;
  logic [AMT_W-1:0] rem_prev = '0;

  // Hopper model: raises ack 2 cycles after req, drops it once req falls
  always @(posedge clk) begin
    #1;
    if (!hif.coin_req) begin
      hif.coin_ack = 1'b0;
      req_age = 0;
    end else if (ack_en && !hif.coin_ack) begin
      req_age++;
      if (req_age == 2) begin
        hif.coin_ack = 1'b1;
        sel_log.push_back(int'(hif.coin_sel));
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (hif.coin_req) req_cycles++;
    if (remaining != rem_prev) begin
      rem_log.push_back(int'(remaining));
      rem_prev = remaining;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int q[$]);
    logic [63:0] acc = '0;
    foreach (q[i]) acc = (acc << 8) | 64'(q[i] & 8'hff);
    return acc;
  endfunction

  task automatic clear_logs();
    sel_log.delete();
    rem_log.delete();
    done_cnt   = 0;
    req_cycles = 0;
  endtask

  task automatic pulse_start(input logic [AMT_W-1:0] amt);
    @(posedge clk); #1;
    start  = 1'b1;
    amount = amt;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Waits at negedges for done; lat counts negedges, first one is lat=1
  task automatic wait_done(input string tag, input int budget, output int lat);
    lat = 0;
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  int lat;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    amount  = '0;
    hif.coin_ack = 1'b0;
    hif.empty25  = 1'b0;
    hif.empty10  = 1'b0;
    hif.empty5   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_outputs", {hif.coin_req, hif.coin_sel, busy, done, short, fault, 3'b0, remaining},
        64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: amount 8, all tubes full
    clear_logs();
    pulse_start(5'd8);
    chk("t1_req_in_select", 64'(hif.coin_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_req_first_high", {62'd0, hif.coin_sel}, 64'd3);
    wait_done("t1", 200, lat);
    chk("t1_done_flags", {busy, short, fault}, 64'b100);
    chk("t1_sel_seq", pack(sel_log), 64'h03_02_01);
    chk("t1_rem_seq", pack(rem_log), 64'h08_03_01_00);
    @(negedge clk);
    chk("t1_after_done", {busy, done}, 64'b00);
    repeat (3) @(negedge clk);
    chk("t1_one_done", 64'(done_cnt), 64'd1);

    // 2: amount 7, 25c tube empty
    clear_logs();
    hif.empty25 = 1'b1;
    pulse_start(5'd7);
    wait_done("t2", 200, lat);
    chk("t2_short", {short, fault}, 64'b00);
    chk("t2_sel_seq", pack(sel_log), 64'h02_02_02_01);
    chk("t2_rem_seq", pack(rem_log), 64'h07_05_03_01_00);
    hif.empty25 = 1'b0;
    repeat (2) @(negedge clk);

    // 3: amount 3, only 25c available -> immediate shortfall
    clear_logs();
    hif.empty10 = 1'b1;
    hif.empty5  = 1'b1;
    pulse_start(5'd3);
    wait_done("t3", 50, lat);
    chk("t3_latency", 64'(lat), 64'd2);
    chk("t3_flags", {short, fault}, 64'b10);
    chk("t3_remaining", 64'(remaining), 64'd3);
    chk("t3_no_req", 64'(req_cycles), 64'd0);
    hif.empty10 = 1'b0;
    hif.empty5  = 1'b0;
    repeat (2) @(negedge clk);

    // 4: hopper never acks -> timeout fault
    clear_logs();
    ack_en = 1'b0;
    pulse_start(5'd5);
    wait_done("t4", 100, lat);
    chk("t4_req_cycles", 64'(req_cycles), 64'd16);
    chk("t4_flags", {short, fault}, 64'b01);
    chk("t4_remaining", 64'(remaining), 64'd5);
    chk("t4_req_low", {hif.coin_req, hif.coin_sel}, 64'd0);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);

    // 5: second start while busy is ignored
    clear_logs();
    pulse_start(5'd5);
    pulse_start(5'd20);
    wait_done("t5", 200, lat);
    repeat (6) @(negedge clk);
    chk("t5_done_count", 64'(done_cnt), 64'd1);
    chk("t5_sel_seq", pack(sel_log), 64'h03);
    chk("t5_remaining", 64'(remaining), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

    // 6: asynchronous reset mid-handshake
    clear_logs();
    pulse_start(5'd8);
    lat = 0;
    while (!hif.coin_req && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_req_seen", 64'(hif.coin_req), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_clear", {hif.coin_req, busy, 3'b0, remaining}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after", {busy, done, hif.coin_req}, 64'd0);
    clear_logs();
    pulse_start(5'd2);
    wait_done("t6", 200, lat);
    chk("t6_sel_seq", pack(sel_log), 64'h02);
    chk("t6_rem_seq", pack(rem_log), 64'h02_00);
    chk("t6_flags", {short, fault}, 64'b00);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change owed by the vending FSM, converting a nickel-count amount into a sequence of coin-eject requests to the coin hopper.
- Uses greedy selection (25c, then 10c, then 5c) and falls back to smaller coins when a hopper tube is empty.
- Sits between the vending FSM change-amount output and the physical hopper interface.
- Reports remaining balance for the seven-segment display and flags shortfall or hopper fault.

Parameters:
AMT_W, 5, width of amount and remaining in nickel units (max 31 = $1.55)
ACK_TIMEOUT, 1_000_000, clk cycles to wait for each hopper handshake edge before faulting

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to pay out amount; sampled only in IDLE
amount  input  AMT_W  change owed in nickel units, captured with start
empty25  input  1  25c tube empty
empty10  input  1  10c tube empty
empty5  input  1  5c tube empty
coin_ack  input  1  hopper acknowledge, 4-phase
coin_req  output  1  eject request to hopper
coin_sel  output  2  coin type: 00 none, 01 5c, 10 10c, 11 25c
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of payout
short  output  1  payout incomplete because no usable coin remained; valid from done until next accepted start
fault  output  1  hopper handshake timed out; valid from done until next accepted start
remaining  output  AMT_W  nickels still owed; shows the captured amount, then decrements per acknowledged coin

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset is asynchronous, so coin_req drops immediately, including mid-handshake.
- States and transitions:
  - IDLE: on start, capture amount into remaining, clear short and fault, go to SELECT. start is ignored in every other state.
  - SELECT (one cycle): evaluate in priority order.
    - remaining==0: go to DONE.
    - remaining>=5 and !empty25: sel=25c, go to REQ.
    - else remaining>=2 and !empty10: sel=10c, go to REQ.
    - else !empty5: sel=5c, go to REQ.
    - else: set short, go to DONE.
  - REQ: coin_req=1, coin_sel held stable. When coin_ack is sampled 1:
    - subtract the coin value from remaining (5, 2 or 1 nickels);
    - drop coin_req and set coin_sel=00 on the next cycle;
    - go to RELEASE.
  - RELEASE: wait for coin_ack==0, then go to SELECT.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - start in cycle N: SELECT in N+1, coin_req first high in N+2.
  - Each coin takes at least 4 cycles: REQ, ack seen, RELEASE, SELECT.
- Empty flags are sampled only in SELECT. A flag changing during REQ does not abort the coin in progress.
- Subtraction never underflows: selection guarantees the coin value is at most remaining.
- Timeout:
  - A cycle counter restarts on entry to REQ and on entry to RELEASE.
  - If ACK_TIMEOUT cycles elapse in either state: set fault, drop coin_req, go to DONE.
  - remaining is not decremented for the unacknowledged coin.
- coin_ack high while in IDLE or SELECT is ignored. SELECT does not proceed to REQ until coin_ack==0; the counter keeps running and faults if coin_ack stays high.
- start coinciding with reset deassertion is not captured.
- All outputs are registered.

Test Plan:
1. Amount 8, no hoppers empty, hopper acks 2 cycles after req:
   - coin_sel sequence 11, 10, 01;
   - remaining 8 → 3 → 1 → 0;
   - one done pulse with short=0, fault=0; busy falls the cycle after done.
2. Amount 7, empty25=1: coin_sel 10, 10, 10, then 01; remaining 7 → 5 → 3 → 1 → 0; done with short=0.
3. Amount 3, empty10=1 and empty5=1: no coin_req ever asserted; done 2 cycles after start with short=1, remaining=3.
4. Amount 5, hopper never acks, ACK_TIMEOUT=16:
   - coin_req high for 16 cycles, then low;
   - done with fault=1, remaining=5.
5. Amount 5 in progress, second start with amount 20 asserted while busy:
   - second start ignored;
   - single 25c coin, remaining ends 0, exactly one done.
6. reset_n pulsed low while coin_req=1: coin_req, busy and remaining go to 0 without waiting for clk; state is IDLE after release and a new start is accepted.
